// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: pointer width rule, minimum synchroniser depth,
// and width-generic binary/Gray conversions (operate on 32 bits, callers cast down).
package async_fifo_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs keep the upper prefix-XOR at zero, so any width works
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_empty_ctrl_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Shared by the read and write pointer blocks.
module gray_sync
  import async_fifo_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("gray_sync: STAGES below minimum");
  end

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer and empty/level controller for the async FIFO.
// Define ASYNC_FIFO_RD_LEVEL_EN to build rd_level and the threshold almost_empty.
module rd_ptr_empty_ctrl
  import async_fifo_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 3,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1,
  localparam int         PTR_W       = ptr_width(ADDR_WIDTH)
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  r_en,
  input  logic [PTR_W-1:0]      g_wptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [PTR_W-1:0]      b_rptr,
  output logic [PTR_W-1:0]      g_rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_W-1:0]      rd_level,
  output logic                  rd_underflow
);

  logic [PTR_W-1:0] g_wptr_sync;
  logic [PTR_W-1:0] b_rptr_nxt;
  logic [PTR_W-1:0] g_rptr_nxt;
  logic             rd_fire;

  gray_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (PTR_W)
  ) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (rrst_n),
    .d     (g_wptr),
    .q     (g_wptr_sync)
  );

  assign rd_fire    = r_en & ~empty;
  assign b_rptr_nxt = b_rptr + PTR_W'(rd_fire);
  assign g_rptr_nxt = PTR_W'(bin2gray(32'(b_rptr_nxt)));
  assign r_addr     = b_rptr[ADDR_WIDTH-1:0];

  // Empty compares against the post-read pointer so the last read closes it
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      rd_underflow <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_nxt;
      g_rptr       <= g_rptr_nxt;
      empty        <= (g_rptr_nxt == g_wptr_sync);
      rd_underflow <= r_en & empty;
    end
  end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] w_bin_sync;
  logic [PTR_W-1:0] level_nxt;

  assign w_bin_sync = PTR_W'(gray2bin(32'(g_wptr_sync)));
  assign level_nxt  = w_bin_sync - b_rptr_nxt;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_nxt;
      almost_empty <= (32'(level_nxt) <= AE_THRESH);
    end
  end
`else
  assign rd_level     = '0;
  assign almost_empty = empty;
`endif

endmodule
